// File: rtl/lc3_cc_stack_unit.sv
// lc3_cc_stack_unit
//   Condition-code unit for the LC-3 datapath. It derives N/Z/P from the bus,
//   registers the branch-enable decision, and keeps a small LIFO of saved NZP
//   values. Interrupt entry pushes the current codes and RTI pops them back,
//   so nested contexts keep their own condition codes.
//
// Ports
//   i_CLK        system clock, all state on the rising edge
//   i_RST_N      synchronous reset, active low, overrides every other input
//   i_Bus        datapath bus value used for CC derivation
//   i_LD_CC      load NZP from the bus-derived codes
//   i_LD_PSR     load NZP verbatim from i_PSR_NZP
//   i_PSR_NZP    NZP field from the PSR write path
//   i_LD_BEN     capture |(i_IR_nzp & o_NZP) into o_BEN
//   i_IR_nzp     IR[11:9] branch mask
//   i_CC_Push    save the current NZP onto the stack
//   i_CC_Pop     restore NZP from the stack top
//   o_NZP        current condition codes {N,Z,P}
//   o_BEN        registered branch enable
//   o_Depth      number of stacked entries
//   o_Stack_Ovf  sticky: push attempted while full
//   o_Stack_Unf  sticky: pop attempted while empty
//
// Build option
//   CC_STACK_ERR_EN  when defined, o_Stack_Ovf/o_Stack_Unf are live sticky
//                    flags; otherwise both are tied low and no flag registers
//                    exist. Stack misuse is silently ignored in both builds.

module lc3_cc_stack_unit #(
  parameter int          DATA_W      = 16,
  parameter int          STACK_DEPTH = 4,
  parameter logic [2:0]  RESET_NZP   = 3'b010,
  localparam int         DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic               i_CLK,
  input  logic               i_RST_N,
  input  logic [DATA_W-1:0]  i_Bus,
  input  logic               i_LD_CC,
  input  logic               i_LD_PSR,
  input  logic [2:0]         i_PSR_NZP,
  input  logic               i_LD_BEN,
  input  logic [2:0]         i_IR_nzp,
  input  logic               i_CC_Push,
  input  logic               i_CC_Pop,
  output logic [2:0]         o_NZP,
  output logic               o_BEN,
  output logic [DEPTH_W-1:0] o_Depth,
  output logic               o_Stack_Ovf,
  output logic               o_Stack_Unf
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [2:0]         nzp_q;
  logic               ben_q;
  logic [DEPTH_W-1:0] depth_q;
  logic [2:0]         stack_q [STACK_DEPTH];

  logic               cc_n, cc_z, cc_p;
  logic               stack_empty, stack_full;
  logic               do_pop, do_push;
  logic [IDX_W-1:0]   wr_idx, rd_idx;

  assign cc_n = i_Bus[DATA_W-1];
  assign cc_z = (i_Bus == '0);
  assign cc_p = !cc_n && !cc_z;

  assign stack_empty = (depth_q == '0);
  assign stack_full  = (depth_q == DEPTH_W'(STACK_DEPTH));

  // Pop wins over push; a push in the same cycle is dropped even when the
  // pop itself is ignored because the stack is empty.
  assign do_pop  = i_CC_Pop && !stack_empty;
  assign do_push = i_CC_Push && !i_CC_Pop && !stack_full;

  assign wr_idx = IDX_W'(depth_q);
  assign rd_idx = IDX_W'(depth_q - DEPTH_W'(1));

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      nzp_q   <= RESET_NZP;
      ben_q   <= 1'b0;
      depth_q <= '0;
    end else begin
      // BEN sees the pre-edge codes, never a same-cycle CC load.
      if (i_LD_BEN)
        ben_q <= |(i_IR_nzp & nzp_q);

      if (do_pop)
        nzp_q <= stack_q[rd_idx];
      else if (i_LD_PSR)
        nzp_q <= i_PSR_NZP;
      else if (i_LD_CC)
        nzp_q <= {cc_n, cc_z, cc_p};

      if (do_pop)
        depth_q <= depth_q - DEPTH_W'(1);
      else if (do_push)
        depth_q <= depth_q + DEPTH_W'(1);
    end
  end

  // Stack storage needs no reset; entries above depth are never read.
  always_ff @(posedge i_CLK) begin
    if (i_RST_N && do_push)
      stack_q[wr_idx] <= nzp_q;
  end

`ifdef CC_STACK_ERR_EN
  logic ovf_q, unf_q;

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (i_CC_Push && !i_CC_Pop && stack_full)
        ovf_q <= 1'b1;
      if (i_CC_Pop && stack_empty)
        unf_q <= 1'b1;
    end
  end

  assign o_Stack_Ovf = ovf_q;
  assign o_Stack_Unf = unf_q;
`else
  assign o_Stack_Ovf = 1'b0;
  assign o_Stack_Unf = 1'b0;
`endif

  assign o_NZP   = nzp_q;
  assign o_BEN   = ben_q;
  assign o_Depth = depth_q;

endmodule

// File: tb/tb_lc3_cc_stack_unit.sv
module tb_lc3_cc_stack_unit;

  localparam int DEPTH = 4;

  logic        i_CLK = 1'b0;
  logic        i_RST_N;
  logic [15:0] i_Bus;
  logic        i_LD_CC, i_LD_PSR, i_LD_BEN, i_CC_Push, i_CC_Pop;
  logic [2:0]  i_PSR_NZP, i_IR_nzp;
  logic [2:0]  o_NZP;
  logic        o_BEN;
  logic [2:0]  o_Depth;
  logic        o_Stack_Ovf, o_Stack_Unf;

  lc3_cc_stack_unit #(
    .DATA_W(16), .STACK_DEPTH(DEPTH), .RESET_NZP(3'b010)
  ) dut (
    .i_CLK(i_CLK), .i_RST_N(i_RST_N), .i_Bus(i_Bus),
    .i_LD_CC(i_LD_CC), .i_LD_PSR(i_LD_PSR), .i_PSR_NZP(i_PSR_NZP),
    .i_LD_BEN(i_LD_BEN), .i_IR_nzp(i_IR_nzp),
    .i_CC_Push(i_CC_Push), .i_CC_Pop(i_CC_Pop),
    .o_NZP(o_NZP), .o_BEN(o_BEN), .o_Depth(o_Depth),
    .o_Stack_Ovf(o_Stack_Ovf), .o_Stack_Unf(o_Stack_Unf)
  );

  always #5 i_CLK = ~i_CLK;

  typedef struct {
    logic [2:0] nzp;
    logic       ben;
    logic [2:0] depth;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;

  // reference model state
  logic [2:0] m_nzp = 3'b010;
  logic       m_ben = 1'b0;
  logic [2:0] m_stk[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] cc_of(input logic [15:0] b);
    if (b[15])         return 3'b100;
    else if (b == '0)  return 3'b010;
    else               return 3'b001;
  endfunction

  task automatic cyc(input logic rst_n, input logic [15:0] bus, input logic ld_cc,
                     input logic ld_psr, input logic [2:0] psr, input logic ld_ben,
                     input logic [2:0] ir, input logic push, input logic pop);
    logic [2:0] pre;
    exp_t       e;
    pre = m_nzp;
    if (!rst_n) begin
      m_nzp = 3'b010; m_ben = 1'b0; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      if (ld_ben) m_ben = |(ir & pre);
      if (pop && m_stk.size() > 0) m_nzp = m_stk.pop_back();
      else if (ld_psr)             m_nzp = psr;
      else if (ld_cc)              m_nzp = cc_of(bus);
`ifdef CC_STACK_ERR_EN
      if (pop && m_stk.size() == 0 && pre == pre) m_unf = m_unf | (m_stk.size() == 0);
`endif
      if (push && !pop) begin
        if (m_stk.size() < DEPTH) m_stk.push_back(pre);
`ifdef CC_STACK_ERR_EN
        else m_ovf = 1'b1;
`endif
      end
    end
    e.nzp = m_nzp; e.ben = m_ben; e.depth = 3'(m_stk.size());
    e.ovf = m_ovf; e.unf = m_unf;
    sb_q.push_back(e);

    i_RST_N = rst_n; i_Bus = bus; i_LD_CC = ld_cc; i_LD_PSR = ld_psr;
    i_PSR_NZP = psr; i_LD_BEN = ld_ben; i_IR_nzp = ir;
    i_CC_Push = push; i_CC_Pop = pop;
    @(posedge i_CLK);
    #1;
    e = sb_q.pop_front();
    chk("nzp",   32'(o_NZP),       32'(e.nzp));
    chk("ben",   32'(o_BEN),       32'(e.ben));
    chk("depth", 32'(o_Depth),     32'(e.depth));
    chk("ovf",   32'(o_Stack_Ovf), 32'(e.ovf));
    chk("unf",   32'(o_Stack_Unf), 32'(e.unf));
  endtask

`ifdef CC_STACK_ERR_EN
  localparam logic FLAG_ON = 1'b1;
`else
  localparam logic FLAG_ON = 1'b0;
`endif

  initial begin
    logic [2:0] ld_seq [5];
    i_RST_N = 1'b0; i_Bus = '0; i_LD_CC = 0; i_LD_PSR = 0; i_PSR_NZP = '0;
    i_LD_BEN = 0; i_IR_nzp = '0; i_CC_Push = 0; i_CC_Pop = 0;
    #2;
    cyc(0, 16'h0, 0, 0, 3'b000, 0, 3'b000, 0, 0);
    cyc(0, 16'h0, 0, 0, 3'b000, 0, 3'b000, 0, 0);
    chk("rst_nzp", 32'(o_NZP), 32'h2);
    chk("rst_depth", 32'(o_Depth), 32'h0);

    // 1: CC derivation
    cyc(1, 16'h8001, 1, 0, 3'b000, 0, 3'b000, 0, 0);
    chk("t1_neg", 32'(o_NZP), 32'h4);
    cyc(1, 16'h0000, 1, 0, 3'b000, 0, 3'b000, 0, 0);
    chk("t1_zero", 32'(o_NZP), 32'h2);
    cyc(1, 16'h7FFF, 1, 0, 3'b000, 0, 3'b000, 0, 0);
    chk("t1_pos", 32'(o_NZP), 32'h1);

    // 2: BEN
    cyc(1, 16'h0, 0, 0, 3'b000, 1, 3'b011, 0, 0);
    chk("t2_ben1", 32'(o_BEN), 32'h1);
    cyc(1, 16'h0, 0, 0, 3'b000, 1, 3'b100, 0, 0);
    chk("t2_ben0", 32'(o_BEN), 32'h0);
    cyc(1, 16'h8000, 1, 0, 3'b000, 1, 3'b100, 0, 0);
    chk("t2_old_nzp", 32'(o_BEN), 32'h0);
    chk("t2_nzp", 32'(o_NZP), 32'h4);

    // 3: push with same-cycle LD_CC, then pop
    cyc(1, 16'h0, 1, 0, 3'b000, 0, 3'b000, 1, 0);
    chk("t3_nzp", 32'(o_NZP), 32'h2);
    chk("t3_depth", 32'(o_Depth), 32'h1);
    cyc(1, 16'h0, 0, 0, 3'b000, 0, 3'b000, 0, 1);
    chk("t3_pop", 32'(o_NZP), 32'h4);
    chk("t3_depth0", 32'(o_Depth), 32'h0);

    // 4: fill past full, then drain LIFO
    ld_seq = '{3'b001, 3'b010, 3'b011, 3'b110, 3'b111};
    for (int i = 0; i < 5; i++) cyc(1, 16'h0, 0, 1, ld_seq[i], 0, 3'b000, 1, 0);
    chk("t4_depth", 32'(o_Depth), 32'h4);
    chk("t4_ovf", 32'(o_Stack_Ovf), 32'(FLAG_ON));
    cyc(1, 16'h0, 0, 0, 3'b000, 0, 3'b000, 0, 1);
    chk("t4_pop1", 32'(o_NZP), 32'h3);
    cyc(1, 16'h0, 0, 0, 3'b000, 0, 3'b000, 0, 1);
    chk("t4_pop2", 32'(o_NZP), 32'h2);
    cyc(1, 16'h0, 0, 0, 3'b000, 0, 3'b000, 0, 1);
    chk("t4_pop3", 32'(o_NZP), 32'h1);
    cyc(1, 16'h0, 0, 0, 3'b000, 0, 3'b000, 0, 1);
    chk("t4_pop4", 32'(o_NZP), 32'h4);

    // 5: pop on empty with LD_PSR; push+pop at depth 2
    cyc(1, 16'h0, 0, 1, 3'b001, 0, 3'b000, 0, 1);
    chk("t5_nzp", 32'(o_NZP), 32'h1);
    chk("t5_unf", 32'(o_Stack_Unf), 32'(FLAG_ON));
    chk("t5_depth0", 32'(o_Depth), 32'h0);
    cyc(1, 16'h0, 0, 0, 3'b000, 0, 3'b000, 1, 0);
    cyc(1, 16'h0, 0, 0, 3'b000, 0, 3'b000, 1, 0);
    cyc(1, 16'h0, 0, 0, 3'b000, 0, 3'b000, 1, 1);
    chk("t5_pushpop", 32'(o_Depth), 32'h1);

    // 6: mid-stack reset with a push in the reset cycle
    cyc(1, 16'h0, 0, 0, 3'b000, 0, 3'b000, 1, 0);
    cyc(1, 16'h8000, 1, 0, 3'b000, 1, 3'b111, 1, 0);
    chk("t6_depth3", 32'(o_Depth), 32'h3);
    cyc(0, 16'h8000, 1, 0, 3'b000, 1, 3'b111, 1, 0);
    chk("t6_nzp", 32'(o_NZP), 32'h2);
    chk("t6_depth", 32'(o_Depth), 32'h0);
    chk("t6_ben", 32'(o_BEN), 32'h0);
    chk("t6_ovf", 32'(o_Stack_Ovf), 32'h0);
    chk("t6_unf", 32'(o_Stack_Unf), 32'h0);

    // random traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic [15:0] b;
      case ($urandom_range(0, 3))
        0: b = 16'h0000;
        1: b = 16'(16'h8000 | 16'($urandom_range(0, 16'h7FFF)));
        default: b = 16'($urandom_range(0, 16'hFFFF));
      endcase
      cyc(($urandom_range(0, 39) != 0), b, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
